// File: rtl/lsu_ctrl.sv
// ============================================================================
// Module   : lsu_ctrl
// Purpose  : Single-outstanding load/store controller for a word-addressed
//            synchronous-read data memory, with alignment/range checking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_ctrl #(
  parameter int DEPTH = 32,
  parameter int IDX_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        req_ready,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_err
);

  localparam logic [1:0]  c_IDLE    = 2'd0;
  localparam logic [1:0]  c_ISSUE   = 2'd1;
  localparam logic [1:0]  c_CAPTURE = 2'd2;
  localparam logic [1:0]  c_RESP    = 2'd3;
  localparam logic [32:0] c_LIMIT   = 33'(DEPTH) * 33'd4;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic             r_write;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;
  logic [4:0]       r_rd;
  logic             r_err;
  logic [31:0]      r_rdata;
  logic             w_accept;
  logic             w_addr_err;

  assign w_accept   = req_valid && (r_state == c_IDLE);
  // Byte addresses at or beyond DEPTH words are rejected rather than wrapped.
  assign w_addr_err = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= c_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:    if (w_accept) w_next = w_addr_err ? c_RESP : c_ISSUE;
      c_ISSUE:   w_next = r_write ? c_RESP : c_CAPTURE;
      c_CAPTURE: w_next = c_RESP;
      c_RESP:    if (resp_ready) w_next = c_IDLE;
      default:   w_next = c_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    req_ready  = (r_state == c_IDLE);
    mem_read   = (r_state == c_ISSUE) && !r_write;
    mem_write  = (r_state == c_ISSUE) && r_write;
    resp_valid = (r_state == c_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else if (w_accept) begin
      r_write <= req_write;
      r_idx   <= req_addr[IDX_W+1:2];
      r_wdata <= req_wdata;
      r_rd    <= req_rd;
      r_err   <= w_addr_err;
      r_rdata <= '0;
    end else if (r_state == c_CAPTURE) begin
      r_rdata <= mem_read_data;
    end
  end

  assign mem_address    = {{(32-IDX_W){1'b0}}, r_idx};
  assign mem_write_data = r_wdata;
  assign resp_data      = r_rdata;
  assign resp_rd        = r_rd;
  assign resp_err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
// Module   : tb_lsu_ctrl
// Purpose  : Scoreboard bench for lsu_ctrl with a synchronous-read memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        req_ready;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } resp_t;

  resp_t       sb_q[$];
  resp_t       mon_e;
  logic [31:0] mem [32];
  int          checks = 0;
  int          errors = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  int          exp_rd = 0;
  int          exp_wr = 0;
  logic [31:0] last_rd_addr = '0;
  logic [31:0] last_wr_addr = '0;

  always #5 clk = ~clk;

  lsu_ctrl #(.DEPTH(32), .IDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .req_ready(req_ready),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_err(resp_err)
  );

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'(2 * i);
  end

  // Memory model: one-cycle synchronous read, write on the strobe edge.
  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_address[4:0]] <= mem_write_data;
      n_wr                  <= n_wr + 1;
      last_wr_addr          <= mem_address;
    end
    if (mem_read) begin
      mem_read_data <= mem[mem_address[4:0]];
      n_rd          <= n_rd + 1;
      last_rd_addr  <= mem_address;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (mem_read && mem_write) begin
        errors++;
        $display("FAIL strobe_overlap actual=read%b/write%b required=not both", mem_read, mem_write);
      end
      if (resp_valid && resp_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=rd %0d required=no response", resp_rd);
        end else begin
          mon_e = sb_q.pop_front();
          chk("resp_data", resp_data, mon_e.data);
          chk("resp_rd", 32'(resp_rd), 32'(mon_e.rd));
          chk("resp_err", 32'(resp_err), 32'(mon_e.err));
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input logic [31:0] exp_d,
                       input logic exp_e, input int exp_lat, input int hold);
    int    n;
    resp_t r;
    wait_ready();
    resp_ready = (hold == 0);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_rd     = rd;
    r.data = exp_d;
    r.rd   = rd;
    r.err  = exp_e;
    sb_q.push_back(r);
    if (!exp_e) begin
      if (w) exp_wr++;
      else   exp_rd++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    if (hold > 0) begin
      // A stray store held on req_valid while busy must be ignored.
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_data", resp_data, exp_d);
        chk("hold_rd", 32'(resp_rd), 32'(rd));
        chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
    end
    chk("rd_strobes", 32'(n_rd), 32'(exp_rd));
    chk("wr_strobes", 32'(n_wr), 32'(exp_wr));
    if (!exp_e) chk("mem_address", w ? last_wr_addr : last_rd_addr, {27'd0, a[6:2]});
  endtask

  initial begin
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(1'b0, 32'h0000_000C, 32'h0,         5'd7,  32'd6,         1'b0, 3, 0);
    issue(1'b1, 32'h0000_0010, 32'hDEADBEEF,  5'd1,  32'd0,         1'b0, 2, 0);
    issue(1'b0, 32'h0000_0010, 32'h0,         5'd2,  32'hDEADBEEF,  1'b0, 3, 0);
    issue(1'b0, 32'h0000_0006, 32'h0,         5'd3,  32'd0,         1'b1, 1, 0);
    issue(1'b0, 32'h0000_0080, 32'h0,         5'd4,  32'd0,         1'b1, 1, 0);
    issue(1'b0, 32'h0000_007C, 32'h0,         5'd5,  32'h3E,        1'b0, 3, 5);
    issue(1'b1, 32'h0000_0011, 32'h55,        5'd9,  32'd0,         1'b1, 1, 0);
    issue(1'b0, 32'hFFFF_FFFC, 32'h0,         5'd10, 32'd0,         1'b1, 1, 0);

    // Store aborted by reset while its write strobe is up.
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0008;
    req_wdata = 32'h1234_5678;
    req_rd    = 5'd8;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("abort_mem_write", 32'(mem_write), 32'd1);
    chk("abort_mem_address", mem_address, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_mem_write_low", 32'(mem_write), 32'd0);
    chk("abort_mem_address_rst", mem_address, 32'd0);
    chk("abort_wdata_rst", mem_write_data, 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_resp_rd", 32'(resp_rd), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b0, 32'h0000_0008, 32'h0,         5'd6,  32'd4,         1'b0, 3, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
